// File: rtl/acq_carrier_nco_if.sv
// Control, configuration and phase-output bundle of the acquisition carrier NCO.
// master = sweep controller / sample source, slave = the NCO.
interface acq_carrier_nco_if #(
    parameter int ACC_WIDTH = 32,
    parameter int SEG_WIDTH = 12,
    parameter int BIN_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [ACC_WIDTH-1:0] freq_init;
    logic [ACC_WIDTH-1:0] freq_step;
    logic [SEG_WIDTH-1:0] seg_len;
    logic [BIN_WIDTH-1:0] bin_num;
    logic                 sample_valid;
    logic                 busy;
    logic [5:0]           phase;
    logic                 phase_valid;
    logic                 seg_last;
    logic [BIN_WIDTH-1:0] bin_index;
    logic                 sweep_done;

    modport master (
        output start, abort, freq_init, freq_step, seg_len, bin_num, sample_valid,
        input  busy, phase, phase_valid, seg_last, bin_index, sweep_done
    );

    modport slave (
        input  start, abort, freq_init, freq_step, seg_len, bin_num, sample_valid,
        output busy, phase, phase_valid, seg_last, bin_index, sweep_done
    );
endinterface

// File: rtl/acq_carrier_nco.sv
// Carrier NCO feeding the 64-entry sin/cos LUT: one 6-bit phase index per accepted
// sample, sweeping Doppler bins of seg_len samples each, bin_num bins per sweep.
module acq_carrier_nco #(
    parameter int ACC_WIDTH = 32,
    parameter int SEG_WIDTH = 12,
    parameter int BIN_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    acq_carrier_nco_if.slave  nco
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_d;
    logic [ACC_WIDTH-1:0] acc, acc_d;
    logic [ACC_WIDTH-1:0] freq, freq_d;
    logic [ACC_WIDTH-1:0] step, step_d;
    logic [SEG_WIDTH-1:0] seg_max, seg_max_d;
    logic [BIN_WIDTH-1:0] bin_max, bin_max_d;
    logic [SEG_WIDTH-1:0] sample_cnt, sample_cnt_d;
    logic [BIN_WIDTH-1:0] bin, bin_d;

    logic                 busy_q, busy_d;
    logic [5:0]           phase_q, phase_d;
    logic                 pv_q, pv_d;
    logic                 seg_last_q, seg_last_d;
    logic [BIN_WIDTH-1:0] bin_idx_q, bin_idx_d;
    logic                 done_q, done_d;

    logic seg_end, bin_end;

    // Terminal counts are stored as len-1 mod 2^W, so a length of 0 means 2^W.
    assign seg_end = (sample_cnt == seg_max);
    assign bin_end = (bin == bin_max);

    always_comb begin
        state_d      = state;
        acc_d        = acc;
        freq_d       = freq;
        step_d       = step;
        seg_max_d    = seg_max;
        bin_max_d    = bin_max;
        sample_cnt_d = sample_cnt;
        bin_d        = bin;
        pv_d         = 1'b0;
        phase_d      = phase_q;
        seg_last_d   = seg_last_q;
        bin_idx_d    = bin_idx_q;
        done_d       = 1'b0;

        case (state)
            IDLE: begin
                if (nco.start && !nco.abort) begin
                    state_d      = RUN;
                    freq_d       = nco.freq_init;
                    step_d       = nco.freq_step;
                    seg_max_d    = nco.seg_len - SEG_WIDTH'(1);
                    bin_max_d    = nco.bin_num - BIN_WIDTH'(1);
                    acc_d        = '0;
                    sample_cnt_d = '0;
                    bin_d        = '0;
                end
            end
            RUN: begin
                if (nco.abort) begin
                    state_d = IDLE;
                end else if (nco.sample_valid) begin
                    // Index is the accumulator before this sample's add (truncated).
                    pv_d       = 1'b1;
                    phase_d    = acc[ACC_WIDTH-1 -: 6];
                    seg_last_d = seg_end;
                    bin_idx_d  = bin;
                    if (seg_end) begin
                        acc_d        = '0;
                        sample_cnt_d = '0;
                        freq_d       = freq + step;
                        if (bin_end) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            bin_d = bin + BIN_WIDTH'(1);
                        end
                    end else begin
                        acc_d        = acc + freq;
                        sample_cnt_d = sample_cnt + SEG_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            freq       <= '0;
            step       <= '0;
            seg_max    <= '0;
            bin_max    <= '0;
            sample_cnt <= '0;
            bin        <= '0;
            busy_q     <= 1'b0;
            phase_q    <= '0;
            pv_q       <= 1'b0;
            seg_last_q <= 1'b0;
            bin_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_d;
            acc        <= acc_d;
            freq       <= freq_d;
            step       <= step_d;
            seg_max    <= seg_max_d;
            bin_max    <= bin_max_d;
            sample_cnt <= sample_cnt_d;
            bin        <= bin_d;
            busy_q     <= busy_d;
            phase_q    <= phase_d;
            pv_q       <= pv_d;
            seg_last_q <= seg_last_d;
            bin_idx_q  <= bin_idx_d;
            done_q     <= done_d;
        end
    end

    assign nco.busy        = busy_q;
    assign nco.phase       = phase_q;
    assign nco.phase_valid = pv_q;
    assign nco.seg_last    = seg_last_q;
    assign nco.bin_index   = bin_idx_q;
    assign nco.sweep_done  = done_q;
endmodule

// File: tb/tb_acq_carrier_nco.sv
// Directed self-checking bench for acq_carrier_nco; inputs change and outputs are
// checked on the falling edge, so each check sees the result of the preceding rise.
module tb_acq_carrier_nco;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    acq_carrier_nco_if #(.ACC_WIDTH(32), .SEG_WIDTH(12), .BIN_WIDTH(8)) ifc ();

    acq_carrier_nco #(.ACC_WIDTH(32), .SEG_WIDTH(12), .BIN_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .nco (ifc)
    );

    always #5 clk = ~clk;

    // Hand-computed phases for freq_init=0x1000_0000, step=0x0800_0000, seg_len=4, bin_num=3.
    logic [5:0] sweep_ph [12] = '{6'd0, 6'd4, 6'd8, 6'd12,
                                  6'd0, 6'd6, 6'd12, 6'd18,
                                  6'd0, 6'd8, 6'd16, 6'd24};

    // Packed view {phase_valid, phase, seg_last, bin_index, sweep_done, busy}.
    function automatic logic [17:0] ev(input logic pv, input logic [5:0] ph, input logic sl,
                                       input logic [7:0] bi, input logic sd, input logic by);
        return {pv, ph, sl, bi, sd, by};
    endfunction

    function automatic logic [17:0] got();
        return {ifc.phase_valid, ifc.phase, ifc.seg_last, ifc.bin_index, ifc.sweep_done, ifc.busy};
    endfunction

    task automatic do_start(input logic [31:0] fi, input logic [31:0] fs,
                            input logic [11:0] sl, input logic [7:0] bn);
        ifc.freq_init = fi;
        ifc.freq_step = fs;
        ifc.seg_len   = sl;
        ifc.bin_num   = bn;
        ifc.start     = 1'b1;
        @(negedge clk);
        ifc.start     = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        e = ev(1'b0, 6'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        rst = 1'b1;
        ifc.sample_valid = 1'b1;
        ifc.start = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", got(), e);
        end
        rst = 1'b0;
        ifc.start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_idle_sample_ignored: got %h want %h", got(), e);
        end
        ifc.sample_valid = 1'b0;
    endtask

    task automatic test_basic_ramp();
        logic [17:0] e;
        do_start(32'h0400_0000, 32'h0, 12'd64, 8'd1);
        n_cmp++;
        if (ifc.busy !== 1'b1 || ifc.phase_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_busy_after_start: got busy=%b pv=%b want busy=1 pv=0", ifc.busy, ifc.phase_valid);
        end
        for (int i = 0; i < 64; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, 6'(i), i == 63, 8'd0, i == 63, i != 63);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL ramp[%0d]: got %h want %h", i, got(), e);
            end
        end
        @(negedge clk);
        e = ev(1'b0, 6'd63, 1'b1, 8'd0, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL ramp_after_done: got %h want %h", got(), e);
        end
        ifc.sample_valid = 1'b0;
    endtask

    task automatic test_bin_sweep();
        logic [17:0] e;
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        for (int i = 0; i < 12; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, sweep_ph[i], (i % 4) == 3, 8'(i / 4), i == 11, i != 11);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL sweep[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_negative_step();
        logic [17:0] e;
        logic [5:0]  ph [8];
        ph = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd63, 6'd62, 6'd61};
        do_start(32'h0, 32'hFC00_0000, 12'd4, 8'd2);
        for (int i = 0; i < 8; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, ph[i], (i % 4) == 3, 8'(i / 4), i == 7, i != 7);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL negstep[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gapped();
        logic [17:0] e;
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        for (int i = 0; i < 12; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, sweep_ph[i], (i % 4) == 3, 8'(i / 4), i == 11, i != 11);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL gap_valid[%0d]: got %h want %h", i, got(), e);
            end
            ifc.sample_valid = 1'b0;
            @(negedge clk);
            e = ev(1'b0, sweep_ph[i], (i % 4) == 3, 8'(i / 4), 1'b0, i != 11);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL gap_hold[%0d]: got %h want %h", i, got(), e);
            end
        end
    endtask

    task automatic test_control();
        logic [17:0] e;
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        n_cmp++;
        if (ifc.busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_start_idle: got busy=%b want busy=0", ifc.busy);
        end
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                // A start in RUN with different config must not relatch anything.
                ifc.sample_valid = 1'b0;
                do_start(32'h0, 32'h0, 12'd1, 8'd1);
                n_cmp++;
                if (ifc.busy !== 1'b1 || ifc.phase_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL start_in_run: got busy=%b pv=%b want busy=1 pv=0", ifc.busy, ifc.phase_valid);
                end
            end
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, sweep_ph[i], (i % 4) == 3, 8'(i / 4), 1'b0, 1'b1);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL ctrl_run[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        e = ev(1'b0, 6'd0, 1'b0, 8'd1, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL abort_run: got %h want %h", got(), e);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL after_abort_idle: got %h want %h", got(), e);
        end
        ifc.sample_valid = 1'b0;
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL abort_in_idle: got %h want %h", got(), e);
        end
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        for (int i = 0; i < 12; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, sweep_ph[i], (i % 4) == 3, 8'(i / 4), i == 11, i != 11);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL restart[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sweep();
        logic [17:0] e;
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        ifc.sample_valid = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ifc.start = 1'b1;
        ifc.abort = 1'b1;
        @(negedge clk);
        e = ev(1'b0, 6'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_mid_sweep: got %h want %h", got(), e);
        end
        rst = 1'b0;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (got() !== e) begin
            n_err++;
            $display("FAIL reset_then_idle: got %h want %h", got(), e);
        end
        ifc.sample_valid = 1'b0;
        do_start(32'h1000_0000, 32'h0800_0000, 12'd4, 8'd3);
        for (int i = 0; i < 12; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, sweep_ph[i], (i % 4) == 3, 8'(i / 4), i == 11, i != 11);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL post_reset[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_lengths();
        logic [17:0] e;
        // seg_len=0 -> 4096 samples; 0x0010_0000 per sample advances the index every 64.
        do_start(32'h0010_0000, 32'h0, 12'd0, 8'd1);
        for (int i = 0; i < 4096; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, 6'(i / 64), i == 4095, 8'd0, i == 4095, i != 4095);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL seg_len0[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
        // bin_num=0 -> 256 one-sample bins; acc is cleared each bin so phase stays 0.
        do_start(32'h0, 32'h0400_0000, 12'd1, 8'd0);
        for (int i = 0; i < 256; i++) begin
            ifc.sample_valid = 1'b1;
            @(negedge clk);
            e = ev(1'b1, 6'd0, 1'b1, 8'(i), i == 255, i != 255);
            n_cmp++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL bin_num0[%0d]: got %h want %h", i, got(), e);
            end
        end
        ifc.sample_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        ifc.start        = 1'b0;
        ifc.abort        = 1'b0;
        ifc.freq_init    = '0;
        ifc.freq_step    = '0;
        ifc.seg_len      = '0;
        ifc.bin_num      = '0;
        ifc.sample_valid = 1'b0;
        test_reset();
        test_basic_ramp();
        test_bin_sweep();
        test_negative_step();
        test_gapped();
        test_control();
        test_reset_mid_sweep();
        test_zero_lengths();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
